freq_synth: RTL and testbench

- Programmable frequency generator: the transmit-side counterpart of freq_gauge.
- Software writes a target frequency in Hz over Avalon-MM.
- Block computes a phase increment with a multi-cycle divider and drives a phase-accumulator (NCO) that produces a square wave and a per-period strobe.
- Used as an on-chip stimulus source for freq_gauge and for rate-pacing.

---
 rtl/freq_synth_pkg.sv | 13 +
 rtl/freq_synth_if.sv | 11 +
 rtl/freq_synth_div.sv | 69 ++++++
 rtl/freq_synth.sv | 113 +++++++++++
 tb/tb_freq_synth.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/freq_synth_pkg.sv
// Shared constants for the frequency synthesiser: register map, bit positions, FSM states.
package freq_synth_pkg;
  localparam logic [1:0] ADDR_TARGET = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_INCR   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, APPLY} state_e;
endpackage

// File: rtl/freq_synth_if.sv
// Avalon-MM slave bus of the frequency synthesiser (readLatency 1).
interface freq_synth_if;
  logic [1:0]  mm_address;
  logic        mm_write;
  logic [31:0] mm_writedata;
  logic        mm_read;
  logic [31:0] mm_readdata;

  modport master (output mm_address, mm_write, mm_writedata, mm_read, input mm_readdata);
  modport slave  (input mm_address, mm_write, mm_writedata, mm_read, output mm_readdata);
endinterface

// File: rtl/freq_synth_div.sv
// Restoring divider, one quotient bit per cycle. The first bit is resolved on the
// start edge itself, so N bits complete N-1 edges later with done pulsing after that.
module freq_synth_div #(
  parameter int N  = 64,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  numerator,
  input  logic [DW-1:0] denominator,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  quotient
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [DW-1:0] rem_q, den_q, src_rem, src_den;
  logic [N-1:0]  quo_q, src_quo, quo_d;
  logic [DW:0]   trial, rem_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, ge;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? numerator : quo_q;
    src_den = start ? denominator : den_q;
    trial   = {src_rem, src_quo[N-1]};
    ge      = trial >= {1'b0, src_den};
    rem_d   = ge ? trial - {1'b0, src_den} : trial;
    quo_d   = {src_quo[N-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_d[DW-1:0];
      quo_q  <= quo_d;
      den_q  <= denominator;
      cnt_q  <= CNT_INIT;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q  <= rem_d[DW-1:0];
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - 1'b1;
      busy_q <= cnt_q != CNT_LAST;
      done_q <= cnt_q == CNT_LAST;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;
endmodule

// File: rtl/freq_synth.sv
// Programmable NCO: TARGET_HZ is divided into a phase increment, then a phase
// accumulator produces a square wave (MSB) and a tick on every carry-out.
module freq_synth
  import freq_synth_pkg::*;
#(
  parameter longint ReferenceClock = 100000000,
  parameter int     AccWidth       = 32,
  parameter int     FreqWidth      = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  freq_synth_if.slave  mm,
  output logic         wave_out,
  output logic         tick_out
);
  localparam int N  = FreqWidth + AccWidth;
  localparam int DW = 32;
  localparam logic [FreqWidth-1:0] MAX_HZ  = FreqWidth'(ReferenceClock / 2);
  localparam logic [DW-1:0]        REF_DEN = DW'(ReferenceClock);

  state_e                state_q, state_d;
  logic [FreqWidth-1:0]  target_q, wdata_hz;
  logic [AccWidth-1:0]   incr_q, acc_q;
  logic [AccWidth:0]     sum;
  logic [31:0]           rdata_q, status_w;
  logic                  en_q, en_d, err_q, tick_q, busy, load_incr;
  logic                  wr_target, wr_ctrl, div_start, div_abort, div_busy, div_done;
  logic [N-1:0]          div_quo;
  logic                  unused_div;

  assign wdata_hz  = FreqWidth'(mm.mm_writedata);
  assign wr_target = mm.mm_write && mm.mm_address == ADDR_TARGET;
  assign wr_ctrl   = mm.mm_write && mm.mm_address == ADDR_CTRL;
  assign div_start = wr_target && wdata_hz <= MAX_HZ;
  assign div_abort = wr_target && wdata_hz > MAX_HZ;
  assign busy      = state_q != IDLE;
  assign unused_div = div_busy ^ (^div_quo[N-1:AccWidth]);

  freq_synth_div #(.N(N), .DW(DW)) u_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (div_start),
    .abort       (div_abort),
    .numerator   ({wdata_hz, {AccWidth{1'b0}}}),
    .denominator (REF_DEN),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quo)
  );

  // A new TARGET_HZ write wins over any in-flight result, including one about to apply.
  always_comb begin
    state_d   = state_q;
    load_incr = 1'b0;
    case (state_q)
      DIVIDE:  if (div_done) state_d = APPLY;
      APPLY:   begin load_incr = 1'b1; state_d = IDLE; end
      default: state_d = state_q;
    endcase
    if (div_start) begin
      state_d   = DIVIDE;
      load_incr = 1'b0;
    end else if (div_abort) begin
      state_d   = IDLE;
      load_incr = 1'b0;
    end
  end

  always_comb begin
    status_w                = '0;
    status_w[STAT_BUSY_BIT] = busy;
    status_w[STAT_ERR_BIT]  = err_q;
  end

  assign en_d = wr_ctrl ? mm.mm_writedata[CTRL_EN_BIT] : en_q;
  assign sum  = {1'b0, acc_q} + {1'b0, incr_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      incr_q   <= '0;
      acc_q    <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      tick_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      if (wr_target) begin
        target_q <= wdata_hz;
        err_q    <= div_abort;
      end
      if (load_incr) incr_q <= div_quo[AccWidth-1:0];
      // Disabling clears phase immediately; enabling starts from zero phase.
      acc_q  <= en_d ? sum[AccWidth-1:0] : '0;
      tick_q <= en_d & sum[AccWidth];
      if (mm.mm_read) begin
        case (mm.mm_address)
          ADDR_TARGET: rdata_q <= 32'(target_q);
          ADDR_CTRL:   rdata_q <= {31'b0, en_q};
          ADDR_STATUS: rdata_q <= status_w;
          default:     rdata_q <= 32'(incr_q);
        endcase
      end
    end
  end

  assign mm.mm_readdata = rdata_q;
  assign wave_out       = acc_q[AccWidth-1];
  assign tick_out       = tick_q;
endmodule

// File: tb/tb_freq_synth.sv
// Directed bench for freq_synth: a cycle-level behavioural model checked every cycle,
// plus literal expectations for the key register values and waveform properties.
module tb_freq_synth;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wave_out, tick_out;
  int   n_vec = 0;
  int   n_err = 0;

  freq_synth_if bus();

  freq_synth dut (
    .clk      (clk),
    .reset_n  (rst_n),
    .mm       (bus),
    .wave_out (wave_out),
    .tick_out (tick_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: each accepted write schedules its increment 65 edges later.
  logic [31:0] m_target, m_incr, m_pend, m_acc, m_rd;
  logic        m_en, m_err, m_tick;
  int          m_cnt;
  logic        m_en_now;
  logic [32:0] m_sum;

  function automatic logic [31:0] incr_of(input logic [31:0] hz);
    longint unsigned p;
    p = (longint'(hz) << 32) / 64'd100000000;
    return p[31:0];
  endfunction

  assign m_en_now = (bus.mm_write && bus.mm_address == 2'd1) ? bus.mm_writedata[0] : m_en;
  assign m_sum    = {1'b0, m_acc} + {1'b0, m_incr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_target <= 0; m_incr <= 0; m_pend <= 0; m_acc <= 0; m_rd <= 0;
      m_en <= 0; m_err <= 0; m_tick <= 0; m_cnt <= 0;
    end else begin
      m_acc  <= m_en_now ? m_sum[31:0] : 32'd0;
      m_tick <= m_en_now & m_sum[32];
      if (bus.mm_write && bus.mm_address == 2'd1) m_en <= bus.mm_writedata[0];
      if (bus.mm_write && bus.mm_address == 2'd0) begin
        m_target <= bus.mm_writedata;
        m_cnt    <= (bus.mm_writedata > 32'd50000000) ? 0 : 65;
        m_err    <= bus.mm_writedata > 32'd50000000;
        m_pend   <= incr_of(bus.mm_writedata);
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_incr <= m_pend;
      end
      if (bus.mm_read) begin
        case (bus.mm_address)
          2'd0: m_rd <= m_target;
          2'd1: m_rd <= {31'b0, m_en};
          2'd2: m_rd <= {30'b0, m_err, m_cnt > 0};
          default: m_rd <= m_incr;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called at a negedge; the write is sampled on the following posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.mm_address = a; bus.mm_writedata = d; bus.mm_write = 1'b1;
    @(negedge clk);
    bus.mm_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.mm_address = a; bus.mm_read = 1'b1;
    @(negedge clk);
    bus.mm_read = 1'b0;
    check(name, bus.mm_readdata, exp);
  endtask

  task automatic count_ticks(input int cycles, output int ticks, output int toggles);
    logic prev;
    ticks = 0; toggles = 0; prev = wave_out;
    repeat (cycles) begin
      @(negedge clk);
      ticks += int'(tick_out);
      if (wave_out != prev) toggles++;
      prev = wave_out;
    end
  endtask

  initial begin
    int t, g;
    bus.mm_address = 0; bus.mm_write = 0; bus.mm_writedata = 0; bus.mm_read = 0;
    fork
      forever begin
        @(negedge clk);
        check("model_wave", {31'b0, wave_out}, {31'b0, m_acc[31]});
        check("model_tick", {31'b0, tick_out}, {31'b0, m_tick});
        check("model_rdata", bus.mm_readdata, m_rd);
      end
      begin
        repeat (2) @(negedge clk);
        check("rst_rdata", bus.mm_readdata, 32'd0);
        check("rst_wave", {31'b0, wave_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd25000000);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rdata", bus.mm_readdata, 32'd0);
        check("midrst_wave", {31'b0, wave_out}, 32'd0);
        check("midrst_tick", {31'b0, tick_out}, 32'd0);
        rst_n = 1'b1;
        rd(2'd2, 32'd0, "post_rst_status");
        rd(2'd3, 32'd0, "post_rst_incr");
        rd(2'd0, 32'd0, "post_rst_target");
        rd(2'd1, 32'd0, "post_rst_ctrl");

        wr(2'd1, 32'd1);
        count_ticks(10, t, g);
        check("zero_incr_ticks", t, 0);
        wr(2'd0, 32'd25000000);
        bus.mm_address = 2'd2; bus.mm_read = 1'b1;
        for (int k = 1; k <= 66; k++) begin
          @(negedge clk);
          check($sformatf("busy_E%0d", k), bus.mm_readdata & 32'd1, (k <= 65) ? 32'd1 : 32'd0);
        end
        bus.mm_read = 1'b0;
        rd(2'd3, 32'h40000000, "incr_25M");
        count_ticks(40, t, g);
        check("ticks_25M_40cyc", t, 10);
        check("toggles_25M_40cyc", g, 20);

        wr(2'd0, 32'd10000000);
        repeat (70) @(negedge clk);
        rd(2'd3, 32'h19999999, "incr_10M");
        count_ticks(1000, t, g);
        check_range("ticks_10M_1000cyc", t, 99, 101);

        wr(2'd0, 32'd50000000);
        repeat (70) @(negedge clk);
        rd(2'd3, 32'h80000000, "incr_50M");
        count_ticks(8, t, g);
        check("toggles_50M_8cyc", g, 8);
        check("ticks_50M_8cyc", t, 4);

        wr(2'd0, 32'd50000001);
        rd(2'd2, 32'd2, "status_err");
        rd(2'd3, 32'h80000000, "incr_after_err");
        rd(2'd0, 32'd50000001, "target_readback");
        wr(2'd0, 32'd25000000);
        rd(2'd2, 32'd1, "status_err_cleared");
        repeat (70) @(negedge clk);
        rd(2'd3, 32'h40000000, "incr_25M_again");

        wr(2'd0, 32'd50000000);
        repeat (70) @(negedge clk);
        wr(2'd0, 32'd25000000);
        repeat (9) @(negedge clk);
        wr(2'd0, 32'd10000000);
        bus.mm_address = 2'd3; bus.mm_read = 1'b1;
        for (int k = 11; k <= 80; k++) begin
          @(negedge clk);
          check($sformatf("restart_incr_E%0d", k), bus.mm_readdata,
                (k >= 76) ? 32'h19999999 : 32'h80000000);
        end
        bus.mm_read = 1'b0;

        wr(2'd1, 32'd0);
        check("dis_wave", {31'b0, wave_out}, 32'd0);
        check("dis_tick", {31'b0, tick_out}, 32'd0);
        count_ticks(12, t, g);
        check("dis_ticks", t, 0);
        check("dis_toggles", g, 0);

        wr(2'd1, 32'd1);
        wr(2'd0, 32'd10625000);
        repeat (70) @(negedge clk);
        rd(2'd3, 32'd456340275, "incr_10625000");
        count_ticks(1000, t, g);
        check_range("ticks_10625000", t, 105, 107);
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
